// File: rtl/stack_param_if.sv
// Command/result bundle for the LIFO stack core.
// The master drives commands and data in. The slave (the stack) returns the
// read data, the status pulses and the occupancy.
interface stack_param_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 5
);
  localparam int PW = $clog2(DEPTH);

  logic             cmd_valid;
  logic [1:0]       command;
  logic [PW-1:0]    index;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             err;
  logic [PW:0]      count;
  logic             full;
  logic             empty;

  modport master (
    output cmd_valid, command, index, data_in,
    input  data_out, out_valid, err, count, full, empty
  );

  modport slave (
    input  cmd_valid, command, index, data_in,
    output data_out, out_valid, err, count, full, empty
  );
endinterface

// File: rtl/stack_param.sv
// Parametrised LIFO stack over circular storage.
// It accepts one command per clock: NOP, PUSH, POP, or GET (an indexed peek,
// where 0 is the top). When the stack is full, a PUSH either overwrites the
// oldest entry or is rejected, chosen by OVERWRITE.
module stack_param #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 5,
  parameter bit OVERWRITE = 1'b1
) (
  input logic          clk,
  input logic          reset,
  stack_param_if.slave bus
);
  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);
  localparam logic [PW:0] ONE_W   = (PW+1)'(1);

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_PUSH = 2'd1,
    CMD_POP  = 2'd2,
    CMD_GET  = 2'd3
  } cmd_e;

  cmd_e             cmd;
  logic [PW-1:0]    sp_q, sp_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  // The pointer and index arithmetic is done one bit wider than the pointer.
  // Each result is then brought back into 0..DEPTH-1 with one
  // compare-and-subtract, so no divider is needed.
  logic [PW:0] sp_ext, k_ext;
  logic [PW:0] inc_raw, inc_mod;
  logic [PW:0] dec_raw, dec_mod;
  logic [PW:0] get_raw, get_mod;
  logic        full_w, empty_w, get_ok;

  assign cmd     = cmd_e'(bus.command);
  assign sp_ext  = {1'b0, sp_q};
  assign k_ext   = {1'b0, bus.index};
  assign full_w  = (count_q == DEPTH_W);
  assign empty_w = (count_q == '0);

  assign inc_raw = sp_ext + ONE_W;
  assign inc_mod = (inc_raw >= DEPTH_W) ? inc_raw - DEPTH_W : inc_raw;

  // sp-1 is formed as sp+DEPTH-1 so that it never goes below zero.
  assign dec_raw = sp_ext + DEPTH_W - ONE_W;
  assign dec_mod = (dec_raw >= DEPTH_W) ? dec_raw - DEPTH_W : dec_raw;

  // The GET slot is only used when k < COUNT <= DEPTH. In that case get_raw
  // lies in 0..2*DEPTH-2, so a single subtract is enough.
  assign get_ok  = (k_ext < count_q);
  assign get_raw = dec_raw - k_ext;
  assign get_mod = (get_raw >= DEPTH_W) ? get_raw - DEPTH_W : get_raw;

  // Next-state decode for the single command accepted this cycle.
  always_comb begin
    // NOTE: every signal written here is given a value before the case
    // statement. Paths that skip an assignment then keep that value, and no
    // latch is inferred.
    sp_d        = sp_q;
    count_d     = count_q;
    mem_d       = mem_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    if (bus.cmd_valid) begin
      // NOTE: blocking '=' is correct inside combinational logic. The
      // registers below use non-blocking '<=' so that all flops update
      // together on the clock edge.
      case (cmd)
        CMD_PUSH: begin
          if (!full_w || OVERWRITE) begin
            mem_d[sp_q] = bus.data_in;
            sp_d        = inc_mod[PW-1:0];
            if (!full_w) count_d = count_q + ONE_W;
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_POP: begin
          if (!empty_w) begin
            data_out_d  = mem_q[dec_mod[PW-1:0]];
            sp_d        = dec_mod[PW-1:0];
            count_d     = count_q - ONE_W;
            out_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_GET: begin
          if (get_ok) begin
            data_out_d  = mem_q[get_mod[PW-1:0]];
            out_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers. A synchronous reset clears everything and drops any
  // command in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q        <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      // NOTE: storage is not usually reset. Here it is cleared on purpose so
      // that the stack always starts from a known all-zero image.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
endmodule

// File: tb/tb_stack_param.sv
// Self-checking bench for stack_param.
// Two instances receive the same command stream: one overwrites when full,
// the other rejects. Expected read data is queued when a command is issued
// and compared when OUT_VALID appears.
module tb_stack_param;
  localparam int WIDTH = 4;
  localparam int DEPTH = 5;
  localparam logic [1:0] NOP = 2'd0, PUSH = 2'd1, POP = 2'd2, GET = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] command = NOP;
  logic [2:0] index = '0;
  logic [3:0] data_in = '0;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_ow [$];
  logic [3:0] exp_rj [$];

  always #5 clk = ~clk;

  stack_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_ow ();
  stack_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_rj ();

  assign bus_ow.cmd_valid = cmd_valid;
  assign bus_ow.command   = command;
  assign bus_ow.index     = index;
  assign bus_ow.data_in   = data_in;
  assign bus_rj.cmd_valid = cmd_valid;
  assign bus_rj.command   = command;
  assign bus_rj.index     = index;
  assign bus_rj.data_in   = data_in;

  stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OVERWRITE(1'b1)) dut_ow (
    .clk(clk), .reset(reset), .bus(bus_ow)
  );
  stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OVERWRITE(1'b0)) dut_rj (
    .clk(clk), .reset(reset), .bus(bus_rj)
  );

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; command = NOP;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ow.delete(); exp_rj.delete();
  endtask

  // Drive one command, sample 1 ns after the edge, check the ERR pulses and
  // compare any OUT_VALID against the scoreboard.
  task automatic issue(input logic [1:0] c, input logic [2:0] k, input logic [3:0] d,
                       input logic e_ow, input logic e_rj);
    logic [3:0] exp;
    cmd_valid = 1'b1; command = c; index = k; data_in = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0; command = NOP;
    total++;
    if (bus_ow.err !== e_ow) begin
      bad++; $display("FAIL err_ow cmd=%0d got=%b exp=%b", c, bus_ow.err, e_ow);
    end
    total++;
    if (bus_rj.err !== e_rj) begin
      bad++; $display("FAIL err_rj cmd=%0d got=%b exp=%b", c, bus_rj.err, e_rj);
    end
    if (bus_ow.out_valid === 1'b1) begin
      total++;
      if (exp_ow.size() == 0) begin
        bad++; $display("FAIL unexpected_valid_ow cmd=%0d data=%h", c, bus_ow.data_out);
      end else begin
        exp = exp_ow.pop_front();
        if (bus_ow.data_out !== exp) begin
          bad++; $display("FAIL data_ow got=%h exp=%h", bus_ow.data_out, exp);
        end
      end
    end else if (exp_ow.size() != 0) begin
      total++; bad++;
      $display("FAIL missing_valid_ow got=%b exp=1", bus_ow.out_valid);
      exp_ow.delete();
    end
    if (bus_rj.out_valid === 1'b1) begin
      total++;
      if (exp_rj.size() == 0) begin
        bad++; $display("FAIL unexpected_valid_rj cmd=%0d data=%h", c, bus_rj.data_out);
      end else begin
        exp = exp_rj.pop_front();
        if (bus_rj.data_out !== exp) begin
          bad++; $display("FAIL data_rj got=%h exp=%h", bus_rj.data_out, exp);
        end
      end
    end else if (exp_rj.size() != 0) begin
      total++; bad++;
      $display("FAIL missing_valid_rj got=%b exp=1", bus_rj.out_valid);
      exp_rj.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1;
    total += 6;
    if (bus_ow.count !== 4'd0)     begin bad++; $display("FAIL reset_count got=%0d exp=0", bus_ow.count); end
    if (bus_ow.empty !== 1'b1)     begin bad++; $display("FAIL reset_empty got=%b exp=1", bus_ow.empty); end
    if (bus_ow.full !== 1'b0)      begin bad++; $display("FAIL reset_full got=%b exp=0", bus_ow.full); end
    if (bus_ow.data_out !== 4'h0)  begin bad++; $display("FAIL reset_data got=%h exp=0", bus_ow.data_out); end
    if (bus_ow.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus_ow.out_valid); end
    if (bus_ow.err !== 1'b0)       begin bad++; $display("FAIL reset_err got=%b exp=0", bus_ow.err); end
    total++;
    if (bus_rj.count !== 4'd0 || bus_rj.empty !== 1'b1 || bus_rj.data_out !== 4'h0) begin
      bad++; $display("FAIL reset_rj count=%0d empty=%b data=%h exp=0/1/0",
                      bus_rj.count, bus_rj.empty, bus_rj.data_out);
    end
  endtask

  task automatic test_get();
    do_reset();
    issue(PUSH, 0, 4'd3, 0, 0);
    issue(PUSH, 0, 4'd7, 0, 0);
    issue(PUSH, 0, 4'd9, 0, 0);
    exp_ow.push_back(4'd9); exp_rj.push_back(4'd9);
    issue(GET, 0, 0, 0, 0);
    exp_ow.push_back(4'd3); exp_rj.push_back(4'd3);
    issue(GET, 2, 0, 0, 0);
    issue(GET, 3, 0, 1, 1);
    total += 3;
    if (bus_ow.data_out !== 4'd3)  begin bad++; $display("FAIL get_err_hold got=%h exp=3", bus_ow.data_out); end
    if (bus_ow.out_valid !== 1'b0) begin bad++; $display("FAIL get_err_valid got=%b exp=0", bus_ow.out_valid); end
    if (bus_ow.count !== 4'd3)     begin bad++; $display("FAIL get_count got=%0d exp=3", bus_ow.count); end
  endtask

  // Scenarios 3 and 4 run together: both instances see PUSH 1..6 followed by six POPs.
  task automatic test_full_policy();
    do_reset();
    for (int i = 1; i <= 5; i++) issue(PUSH, 0, 4'(i), 0, 0);
    total += 3;
    if (bus_ow.full !== 1'b1 || bus_rj.full !== 1'b1) begin
      bad++; $display("FAIL full_flag got=%b/%b exp=1/1", bus_ow.full, bus_rj.full);
    end
    if (bus_ow.count !== 4'd5) begin bad++; $display("FAIL full_count_ow got=%0d exp=5", bus_ow.count); end
    if (bus_rj.count !== 4'd5) begin bad++; $display("FAIL full_count_rj got=%0d exp=5", bus_rj.count); end
    issue(PUSH, 0, 4'd6, 0, 1);
    total += 2;
    if (bus_ow.count !== 4'd5) begin bad++; $display("FAIL ovw_count_ow got=%0d exp=5", bus_ow.count); end
    if (bus_rj.count !== 4'd5) begin bad++; $display("FAIL rej_count_rj got=%0d exp=5", bus_rj.count); end
    for (int i = 0; i < 5; i++) begin
      exp_ow.push_back(4'(6 - i));
      exp_rj.push_back(4'(5 - i));
      issue(POP, 0, 0, 0, 0);
    end
    total++;
    if (bus_ow.empty !== 1'b1 || bus_rj.empty !== 1'b1) begin
      bad++; $display("FAIL pop_empty got=%b/%b exp=1/1", bus_ow.empty, bus_rj.empty);
    end
    issue(POP, 0, 0, 1, 1);
    total += 2;
    if (bus_ow.out_valid !== 1'b0 || bus_rj.out_valid !== 1'b0) begin
      bad++; $display("FAIL pop_empty_valid got=%b/%b exp=0/0", bus_ow.out_valid, bus_rj.out_valid);
    end
    if (bus_ow.data_out !== 4'd2 || bus_rj.data_out !== 4'd1) begin
      bad++; $display("FAIL pop_empty_hold got=%h/%h exp=2/1", bus_ow.data_out, bus_rj.data_out);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] gets [5];
    gets = '{4'hF, 4'hF, 4'hE, 4'hD, 4'hA};
    do_reset();
    issue(PUSH, 0, 4'hA, 0, 0);
    issue(PUSH, 0, 4'hB, 0, 0);
    issue(PUSH, 0, 4'hC, 0, 0);
    exp_ow.push_back(4'hC); exp_rj.push_back(4'hC); issue(POP, 0, 0, 0, 0);
    exp_ow.push_back(4'hB); exp_rj.push_back(4'hB); issue(POP, 0, 0, 0, 0);
    issue(PUSH, 0, 4'hD, 0, 0);
    issue(PUSH, 0, 4'hE, 0, 0);
    issue(PUSH, 0, 4'hF, 0, 0);
    issue(PUSH, 0, 4'hF, 0, 0);
    for (int k = 0; k < 5; k++) begin
      exp_ow.push_back(gets[k]); exp_rj.push_back(gets[k]);
      issue(GET, 3'(k), 0, 0, 0);
    end
    total++;
    if (bus_ow.count !== 4'd5 || bus_rj.count !== 4'd5) begin
      bad++; $display("FAIL wrap_count got=%0d/%0d exp=5", bus_ow.count, bus_rj.count);
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    issue(PUSH, 0, 4'd2, 0, 0);
    issue(PUSH, 0, 4'd4, 0, 0);
    cmd_valid = 1'b1; command = POP; reset = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; command = NOP; reset = 1'b0;
    total += 3;
    if (bus_ow.out_valid !== 1'b0 || bus_rj.out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset_valid got=%b/%b exp=0/0", bus_ow.out_valid, bus_rj.out_valid);
    end
    if (bus_ow.count !== 4'd0 || bus_rj.count !== 4'd0) begin
      bad++; $display("FAIL mid_reset_count got=%0d/%0d exp=0", bus_ow.count, bus_rj.count);
    end
    if (bus_ow.data_out !== 4'd0) begin
      bad++; $display("FAIL mid_reset_data got=%h exp=0", bus_ow.data_out);
    end
    issue(GET, 0, 0, 1, 1);
  endtask

  // Random commands, checked against a behavioural model of both policies.
  task automatic test_random();
    int         msp [2];
    int         mcnt [2];
    logic [3:0] mmem [2][5];
    logic       e [2];
    logic [1:0] c;
    logic [2:0] k;
    logic [3:0] d;
    logic [3:0] v;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      msp[p] = 0; mcnt[p] = 0;
      for (int i = 0; i < 5; i++) mmem[p][i] = 4'h0;
    end
    for (int n = 0; n < 300; n++) begin
      c = 2'($urandom_range(0, 3));
      k = 3'($urandom_range(0, 7));
      d = 4'($urandom_range(0, 15));
      for (int p = 0; p < 2; p++) begin
        e[p] = 1'b0;
        if (c == PUSH) begin
          if (mcnt[p] < 5 || p == 0) begin
            mmem[p][msp[p]] = d;
            msp[p] = (msp[p] + 1) % 5;
            if (mcnt[p] < 5) mcnt[p]++;
          end else e[p] = 1'b1;
        end else if (c == POP) begin
          if (mcnt[p] > 0) begin
            msp[p] = (msp[p] + 4) % 5;
            v = mmem[p][msp[p]];
            mcnt[p]--;
            if (p == 0) exp_ow.push_back(v); else exp_rj.push_back(v);
          end else e[p] = 1'b1;
        end else if (c == GET) begin
          if (int'(k) < mcnt[p]) begin
            v = mmem[p][(msp[p] + 4 - int'(k)) % 5];
            if (p == 0) exp_ow.push_back(v); else exp_rj.push_back(v);
          end else e[p] = 1'b1;
        end
      end
      issue(c, k, d, e[0], e[1]);
      total++;
      if (int'(bus_ow.count) != mcnt[0] || int'(bus_rj.count) != mcnt[1]) begin
        bad++; $display("FAIL rand_count n=%0d got=%0d/%0d exp=%0d/%0d",
                        n, bus_ow.count, bus_rj.count, mcnt[0], mcnt[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_get();
    test_full_policy();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
